// File: rtl/tlb_asid_pkg.sv
// Shared types and helpers for the ASID-tagged TLB: page-size encodings, walker
// response layout, flush FSM states, tag compare, PA composition and find-first-set.
package tlb_asid_pkg;

   localparam int unsigned PA_WIDTH       = 56;
   localparam int unsigned ASID_W_DEFAULT = 16;

   typedef enum logic [1:0] {
      Pg1G  = 2'd0,
      Pg2M  = 2'd1,
      Pg4K  = 2'd2,
      Pg64K = 2'd3
   } pgsize_e;

   // pa_data holds PA[63:12] of the page base.
   typedef struct packed {
      logic [51:0] pa_data;
      pgsize_e     pgsize;
      logic        d;
      logic        r;
      logic        w;
      logic        x;
      logic        u;
   } page_walk_rsp_t;

   typedef enum logic [1:0] {
      StIdle,
      StSweep,
      StDone
   } flush_state_e;

   // tag and vtag both hold VA[39:12]; only the bits above the page offset take part.
   function automatic logic tag_match(logic [27:0] tag, pgsize_e sz, logic [27:0] vtag);
      logic m;
      unique case (sz)
         Pg1G:    m = (tag[27:18] == vtag[27:18]);
         Pg2M:    m = (tag[27:9]  == vtag[27:9]);
         Pg4K:    m = (tag == vtag);
         Pg64K:   m = (tag[27:4]  == vtag[27:4]);
         default: m = 1'b0;
      endcase
      return m;
   endfunction

   function automatic logic [PA_WIDTH-1:0] compose_pa(logic [51:0] pa_data, pgsize_e sz,
                                                      logic [29:0] voff);
      logic [63:0] full;
      unique case (sz)
         Pg1G:    full = {pa_data[51:18], voff[29:0]};
         Pg2M:    full = {pa_data[51:9],  voff[20:0]};
         Pg4K:    full = {pa_data,        voff[11:0]};
         Pg64K:   full = {pa_data[51:4],  voff[15:0]};
         default: full = '0;
      endcase
      return PA_WIDTH'(full);
   endfunction

   function automatic logic [5:0] find_first_set(logic [63:0] vec);
      logic [5:0] idx;
      idx = '0;
      for (int i = 63; i >= 0; i--) begin
         if (vec[i]) idx = 6'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/tlb_asid_plru.sv
// Tree pseudo-LRU for N = 1<<LG_N entries; the victim prefers the lowest-index
// invalid entry and otherwise follows the tree bits from the root.
module plru_tree
   import tlb_asid_pkg::*;
#(
   parameter int unsigned LG_N = 3
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   touch_valid,
   input  logic [LG_N-1:0]        touch_idx,
   input  logic [(1<<LG_N)-1:0]   valid_vec,
   output logic [LG_N-1:0]        victim
);

   localparam int unsigned N = 1 << LG_N;

   // Heap-ordered nodes 1..N-1; a set bit steers the victim to the upper half.
   logic [N-1:1]    tree_q, tree_d;
   logic [LG_N-1:0] plru_idx;
   logic [5:0]      inv_ffs;
   logic            unused_ffs;

   function automatic logic [LG_N-1:0] node_of(int unsigned lvl, logic [LG_N-1:0] idx);
      logic [LG_N:0] t;
      t = {1'b1, idx} >> (LG_N - lvl);
      return t[LG_N-1:0];
   endfunction

   always_comb begin
      tree_d = tree_q;
      if (touch_valid) begin
         for (int l = 0; l < int'(LG_N); l++) begin
            tree_d[node_of(l, touch_idx)] = ~touch_idx[LG_N-1-l];
         end
      end
   end

   always_comb begin
      plru_idx = '0;
      for (int l = 0; l < int'(LG_N); l++) begin
         plru_idx[LG_N-1-l] = tree_q[node_of(l, plru_idx)];
      end
   end

   assign inv_ffs    = find_first_set(64'(~valid_vec));
   assign victim     = (&valid_vec) ? plru_idx : inv_ffs[LG_N-1:0];
   assign unused_ffs = ^inv_ffs;

   always_ff @(posedge clk) begin
      if (!reset_n) tree_q <= '0;
      else          tree_q <= tree_d;
   end

endmodule

// File: rtl/tlb_asid.sv
// ASID-tagged fully-associative TLB: registered one-cycle lookup, tree-PLRU replacement,
// SFENCE.VMA flush engine (full clear or one-entry-per-cycle sweep) and perf counters.
module tlb_asid
   import tlb_asid_pkg::*;
#(
   parameter int unsigned LG_N   = 3,
   parameter int unsigned ASID_W = ASID_W_DEFAULT,
   parameter bit          ISIDE  = 1'b0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [1:0]          priv,
   input  logic                active,
   input  logic                req,
   input  logic [63:0]         va,
   input  logic [ASID_W-1:0]   asid,
   input  logic                sum,
   output logic                hit,
   output logic [PA_WIDTH-1:0] pa,
   output logic                dirty,
   output logic                readable,
   output logic                writable,
   output logic                executable,
   output logic                user,
   output logic                fault,
   output logic                busy,
   input  logic                replace,
   input  logic [63:0]         replace_va,
   input  logic [ASID_W-1:0]   replace_asid,
   input  logic                replace_global,
   input  page_walk_rsp_t      page_walk_rsp,
   input  logic                flush_req,
   input  logic                flush_va_valid,
   input  logic [63:0]         flush_va,
   input  logic                flush_asid_valid,
   input  logic [ASID_W-1:0]   flush_asid,
   output logic                flush_done,
   output logic [63:0]         tlb_hits,
   output logic [63:0]         tlb_accesses
);

   localparam int unsigned N = 1 << LG_N;

   typedef struct packed {
      logic              glob;
      logic [ASID_W-1:0] asid;
      logic [27:0]       tag;
      pgsize_e           pgsize;
      logic [51:0]       pa_data;
      logic              d;
      logic              r;
      logic              w;
      logic              x;
      logic              u;
   } entry_t;

   entry_t            ent_q [N];
   entry_t            new_ent, hit_ent, sw_ent;
   logic [N-1:0]      valid_q, valid_d;
   flush_state_e      state_q, state_d;
   logic [LG_N-1:0]   idx_q, idx_d;
   logic              fva_valid_q, fasid_valid_q;
   logic [27:0]       fva_q;
   logic [ASID_W-1:0] fasid_q;

   logic [N-1:0]      match;
   logic [5:0]        hit_ffs;
   logic [LG_N-1:0]   hit_idx, victim, touch_idx;
   logic              any_match, lookup, do_replace, full_clear, sweep_kill, touch_valid;

   logic                hit_q, hit_d, fault_q, fault_d;
   logic [PA_WIDTH-1:0] pa_q, pa_d;
   logic [4:0]          perm_q, perm_d;
   logic [63:0]         hits_q, acc_q;
   logic                unused_bits;

   // ---------------- lookup match ----------------
   always_comb begin
      match = '0;
      for (int i = 0; i < int'(N); i++) begin
         match[i] = valid_q[i] && tag_match(ent_q[i].tag, ent_q[i].pgsize, va[39:12]) &&
                    (ent_q[i].glob || (ent_q[i].asid == asid));
      end
   end

   assign hit_ffs   = find_first_set(64'(match));
   assign hit_idx   = hit_ffs[LG_N-1:0];
   assign any_match = |match;
   assign hit_ent   = ent_q[hit_idx];

   assign lookup     = req && active && !busy;
   assign do_replace = replace && !busy && !flush_req;

   // ---------------- flush FSM ----------------
   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= StIdle;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         StIdle: begin
            if (flush_req) begin
               state_d = (flush_va_valid || flush_asid_valid) ? StSweep : StDone;
               idx_d   = '0;
            end
         end
         StSweep: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == {LG_N{1'b1}}) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy       = 1'b0;
      flush_done = 1'b0;
      full_clear = 1'b0;
      sweep_kill = 1'b0;
      sw_ent     = ent_q[idx_q];
      unique case (state_q)
         StIdle: full_clear = flush_req && !flush_va_valid && !flush_asid_valid;
         StSweep: begin
            busy       = 1'b1;
            sweep_kill = (!fva_valid_q || tag_match(sw_ent.tag, sw_ent.pgsize, fva_q)) &&
                         (!fasid_valid_q || (!sw_ent.glob && (sw_ent.asid == fasid_q)));
         end
         StDone: begin
            busy       = 1'b1;
            flush_done = 1'b1;
         end
         default: ;
      endcase
   end

   // Flush operands are captured so the sweep does not depend on them being held.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         idx_q         <= '0;
         fva_valid_q   <= 1'b0;
         fasid_valid_q <= 1'b0;
         fva_q         <= '0;
         fasid_q       <= '0;
      end else begin
         idx_q <= idx_d;
         if (state_q == StIdle && flush_req) begin
            fva_valid_q   <= flush_va_valid;
            fasid_valid_q <= flush_asid_valid;
            fva_q         <= flush_va[39:12];
            fasid_q       <= flush_asid;
         end
      end
   end

   // ---------------- entry storage ----------------
   always_comb begin
      valid_d = valid_q;
      if (full_clear) valid_d = '0;
      if (sweep_kill) valid_d[idx_q] = 1'b0;
      if (do_replace) valid_d[victim] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) valid_q <= '0;
      else          valid_q <= valid_d;
   end

   always_comb begin
      new_ent.glob    = replace_global;
      new_ent.asid    = replace_asid;
      new_ent.tag     = replace_va[39:12];
      new_ent.pgsize  = page_walk_rsp.pgsize;
      new_ent.pa_data = page_walk_rsp.pa_data;
      new_ent.d       = page_walk_rsp.d;
      new_ent.r       = page_walk_rsp.r;
      new_ent.w       = page_walk_rsp.w;
      new_ent.x       = page_walk_rsp.x;
      new_ent.u       = page_walk_rsp.u;
   end

   always_ff @(posedge clk) begin
      if (do_replace) ent_q[victim] <= new_ent;
   end

   // Install wins the PLRU update over a concurrent lookup hit.
   assign touch_valid = do_replace || (lookup && any_match);
   assign touch_idx   = do_replace ? victim : hit_idx;

   plru_tree #(
      .LG_N (LG_N)
   ) u_plru (
      .clk         (clk),
      .reset_n     (reset_n),
      .touch_valid (touch_valid),
      .touch_idx   (touch_idx),
      .valid_vec   (valid_q),
      .victim      (victim)
   );

   // ---------------- registered lookup result ----------------
   always_comb begin
      hit_d   = 1'b0;
      fault_d = 1'b0;
      pa_d    = '0;
      perm_d  = '0;
      if (req && !busy) begin
         if (!active) begin
            hit_d = 1'b1;
            pa_d  = va[PA_WIDTH-1:0];
         end else if (any_match) begin
            hit_d   = 1'b1;
            pa_d    = compose_pa(hit_ent.pa_data, hit_ent.pgsize, va[29:0]);
            perm_d  = {hit_ent.d, hit_ent.r, hit_ent.w, hit_ent.x, hit_ent.u};
            fault_d = ((priv == 2'd0) && !hit_ent.u) ||
                      ((priv == 2'd1) && hit_ent.u && (ISIDE || !sum)) ||
                      (ISIDE && !hit_ent.x);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hit_q   <= 1'b0;
         fault_q <= 1'b0;
         pa_q    <= '0;
         perm_q  <= '0;
         hits_q  <= '0;
         acc_q   <= '0;
      end else begin
         hit_q   <= hit_d;
         fault_q <= fault_d;
         pa_q    <= pa_d;
         perm_q  <= perm_d;
         if (lookup) begin
            acc_q <= acc_q + 64'd1;
            if (any_match) hits_q <= hits_q + 64'd1;
         end
      end
   end

   assign hit          = hit_q;
   assign fault        = fault_q;
   assign pa           = pa_q;
   assign dirty        = perm_q[4];
   assign readable     = perm_q[3];
   assign writable     = perm_q[2];
   assign executable   = perm_q[1];
   assign user         = perm_q[0];
   assign tlb_hits     = hits_q;
   assign tlb_accesses = acc_q;

   assign unused_bits = ^{va[63:40], replace_va[63:40], replace_va[11:0], flush_va[63:40],
                          flush_va[11:0], hit_ffs};

endmodule

// File: tb/tb_tlb_asid.sv
// Directed bench for tlb_asid: table of lookup vectors plus hand-written sequences for
// replacement, selective/full flush and reset mid-sweep. Two instances cover ISIDE 0/1.
module tb_tlb_asid;
   import tlb_asid_pkg::*;

   logic                clk = 1'b0;
   logic                reset_n;
   logic [1:0]          priv;
   logic                active, req, sum;
   logic [63:0]         va;
   logic [15:0]         asid;
   logic                replace, replace_global;
   logic [63:0]         replace_va;
   logic [15:0]         replace_asid;
   page_walk_rsp_t      rsp;
   logic                flush_req, flush_va_valid, flush_asid_valid;
   logic [63:0]         flush_va;
   logic [15:0]         flush_asid;

   logic                hit0, fault0, busy0, done0, d0, r0, w0, x0, u0;
   logic [PA_WIDTH-1:0] pa0;
   logic [63:0]         hits0, acc0;
   logic                hit1, fault1, busy1, done1, d1, r1, w1, x1, u1;
   logic [PA_WIDTH-1:0] pa1;
   logic [63:0]         hits1, acc1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tlb_asid #(.LG_N(3), .ASID_W(16), .ISIDE(1'b0)) u_dut (
      .clk(clk), .reset_n(reset_n), .priv(priv), .active(active), .req(req), .va(va),
      .asid(asid), .sum(sum), .hit(hit0), .pa(pa0), .dirty(d0), .readable(r0),
      .writable(w0), .executable(x0), .user(u0), .fault(fault0), .busy(busy0),
      .replace(replace), .replace_va(replace_va), .replace_asid(replace_asid),
      .replace_global(replace_global), .page_walk_rsp(rsp), .flush_req(flush_req),
      .flush_va_valid(flush_va_valid), .flush_va(flush_va),
      .flush_asid_valid(flush_asid_valid), .flush_asid(flush_asid),
      .flush_done(done0), .tlb_hits(hits0), .tlb_accesses(acc0)
   );

   tlb_asid #(.LG_N(3), .ASID_W(16), .ISIDE(1'b1)) u_dut_i (
      .clk(clk), .reset_n(reset_n), .priv(priv), .active(active), .req(req), .va(va),
      .asid(asid), .sum(sum), .hit(hit1), .pa(pa1), .dirty(d1), .readable(r1),
      .writable(w1), .executable(x1), .user(u1), .fault(fault1), .busy(busy1),
      .replace(replace), .replace_va(replace_va), .replace_asid(replace_asid),
      .replace_global(replace_global), .page_walk_rsp(rsp), .flush_req(flush_req),
      .flush_va_valid(flush_va_valid), .flush_va(flush_va),
      .flush_asid_valid(flush_asid_valid), .flush_asid(flush_asid),
      .flush_done(done1), .tlb_hits(hits1), .tlb_accesses(acc1)
   );

   typedef struct {
      string       name;
      logic        req;
      logic        active;
      logic [63:0] va;
      logic [15:0] asid;
      logic [1:0]  priv;
      logic        sum;
      logic        exp_hit;
      logic [63:0] exp_pa;
      logic [4:0]  exp_perm;
      logic        exp_fault;
      logic        exp_fault_i;
   } vec_t;

   vec_t vecs[10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic install(input logic [63:0] v, input logic [15:0] a, input logic g,
                          input logic [63:0] pa_full, input pgsize_e sz,
                          input logic [4:0] perm);
      replace        = 1'b1;
      replace_va     = v;
      replace_asid   = a;
      replace_global = g;
      rsp.pa_data    = pa_full[63:12];
      rsp.pgsize     = sz;
      {rsp.d, rsp.r, rsp.w, rsp.x, rsp.u} = perm;
      tick();
      replace = 1'b0;
   endtask

   task automatic lookup(input logic [63:0] v, input logic [15:0] a);
      req  = 1'b1;
      va   = v;
      asid = a;
      tick();
      req = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int nbusy, done_cyc, saw_hit;
      logic [63:0] acc_before;

      reset_n = 1'b0; priv = 2'd3; active = 1'b1; req = 1'b0; sum = 1'b0;
      va = '0; asid = '0; replace = 1'b0; replace_global = 1'b0; replace_va = '0;
      replace_asid = '0; rsp = '0; flush_req = 1'b0; flush_va_valid = 1'b0;
      flush_asid_valid = 1'b0; flush_va = '0; flush_asid = '0;
      tick();
      tick();
      check("reset_hit", hit0, 0);
      check("reset_fault", fault0, 0);
      check("reset_busy", busy0, 0);
      check("reset_done", done0, 0);
      check("reset_pa", pa0, 0);
      check("reset_perm", {d0, r0, w0, x0, u0}, 0);
      check("reset_hits", hits0, 0);
      check("reset_acc", acc0, 0);
      reset_n = 1'b1;
      tick();

      // ---- table-driven lookups ----
      install(64'h4000_1000, 16'd5, 1'b0, 64'h8_0000_0000, Pg4K, 5'b11111);
      install(64'h0020_0000, 16'd0, 1'b1, 64'h1_0000_0000, Pg2M, 5'b01000);
      install(64'h80_0000_0000, 16'd7, 1'b0, 64'hC000_0000, Pg1G, 5'b11111);
      install(64'h1234_0000, 16'd7, 1'b0, 64'h5_6789_0000, Pg64K, 5'b11111);

      vecs[0] = '{"4k_hit", 1, 1, 64'h4000_1abc, 5, 0, 0, 1, 64'h8_0000_0abc, 5'b11111, 0, 0};
      vecs[1] = '{"4k_asid_miss", 1, 1, 64'h4000_1abc, 6, 0, 0, 0, 0, 0, 0, 0};
      vecs[2] = '{"2m_global_s", 1, 1, 64'h0021_2345, 9, 1, 0, 1, 64'h1_0001_2345,
                  5'b01000, 0, 1};
      vecs[3] = '{"2m_global_u", 1, 1, 64'h0021_2345, 9, 0, 0, 1, 64'h1_0001_2345,
                  5'b01000, 1, 1};
      vecs[4] = '{"1g_s_nosum", 1, 1, 64'h80_1234_5678, 7, 1, 0, 1, 64'hD234_5678,
                  5'b11111, 1, 1};
      vecs[5] = '{"1g_s_sum", 1, 1, 64'h80_1234_5678, 7, 1, 1, 1, 64'hD234_5678,
                  5'b11111, 0, 1};
      vecs[6] = '{"64k_hit", 1, 1, 64'h1234_abcd, 7, 3, 0, 1, 64'h5_6789_abcd,
                  5'b11111, 0, 0};
      vecs[7] = '{"64k_miss", 1, 1, 64'h1235_0000, 7, 3, 0, 0, 0, 0, 0, 0};
      vecs[8] = '{"bare", 1, 0, 64'h1234_5678, 7, 0, 0, 1, 64'h1234_5678, 0, 0, 0};
      vecs[9] = '{"no_req", 0, 1, 64'h4000_1abc, 5, 0, 0, 0, 0, 0, 0, 0};

      for (int i = 0; i < 10; i++) begin
         req    = vecs[i].req;
         active = vecs[i].active;
         va     = vecs[i].va;
         asid   = vecs[i].asid;
         priv   = vecs[i].priv;
         sum    = vecs[i].sum;
         tick();
         check({vecs[i].name, "_hit"}, hit0, vecs[i].exp_hit);
         check({vecs[i].name, "_hit_i"}, hit1, vecs[i].exp_hit);
         check({vecs[i].name, "_fault"}, fault0, vecs[i].exp_fault);
         check({vecs[i].name, "_fault_i"}, fault1, vecs[i].exp_fault_i);
         if (vecs[i].exp_hit) check({vecs[i].name, "_pa"}, pa0, vecs[i].exp_pa);
         if (vecs[i].exp_hit && vecs[i].active)
            check({vecs[i].name, "_perm"}, {d0, r0, w0, x0, u0}, vecs[i].exp_perm);
      end
      req = 1'b0; active = 1'b1; priv = 2'd3; sum = 1'b0;
      check("table_accesses", acc0, 64'd8);
      check("table_hits", hits0, 64'd6);

      // ---- full flush with a concurrent (dropped) replace ----
      flush_req = 1'b1;
      replace = 1'b1; replace_va = 64'h7000_0000; replace_asid = 16'd5; replace_global = 1'b0;
      tick();
      flush_req = 1'b0; replace = 1'b0;
      check("full_flush_busy", busy0, 1);
      check("full_flush_done", done0, 1);
      tick();
      check("full_flush_idle", busy0, 0);
      lookup(64'h7000_0000, 16'd5);
      check("dropped_replace_miss", hit0, 0);
      lookup(64'h4000_1abc, 16'd5);
      check("full_flush_miss", hit0, 0);

      // ---- PLRU: fill, touch 0..6 so entry 7 is the tree victim, install a 9th ----
      for (int i = 0; i < 8; i++)
         install(64'h10_0000 + 64'(i) * 64'h1000, 16'd1, 1'b0,
                 64'h100_0000 + 64'(i) * 64'h1000, Pg4K, 5'b11111);
      begin
         int order[7] = '{6, 4, 5, 0, 1, 2, 3};
         for (int k = 0; k < 7; k++) begin
            lookup(64'h10_0000 + 64'(order[k]) * 64'h1000, 16'd1);
            check($sformatf("plru_touch_%0d", order[k]), hit0, 1);
         end
      end
      install(64'h30_0000, 16'd1, 1'b0, 64'h777_7000, Pg4K, 5'b11111);
      lookup(64'h10_7000, 16'd1);
      check("victim7_old_miss", hit0, 0);
      lookup(64'h30_0abc, 16'd1);
      check("ninth_hit", hit0, 1);
      check("ninth_pa", pa0, 64'h777_7abc);
      for (int i = 0; i < 7; i++) begin
         lookup(64'h10_0000 + 64'(i) * 64'h1000 + 64'h10, 16'd1);
         check($sformatf("survivor_%0d_hit", i), hit0, 1);
         check($sformatf("survivor_%0d_pa", i), pa0, 64'h100_0010 + 64'(i) * 64'h1000);
      end

      // ---- ASID-selective flush ----
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      install(64'h0020_0000, 16'd0, 1'b1, 64'h1_0000_0000, Pg2M, 5'b11111);
      install(64'h5000_3000, 16'd3, 1'b0, 64'h3_0000_0000, Pg4K, 5'b11111);
      install(64'h5000_4000, 16'd4, 1'b0, 64'h4_0000_0000, Pg4K, 5'b11111);
      acc_before = acc0;
      flush_asid_valid = 1'b1; flush_asid = 16'd3; flush_req = 1'b1;
      tick();
      flush_req = 1'b0; flush_asid_valid = 1'b0; flush_asid = '0;
      req = 1'b1; va = 64'h0020_0123; asid = 16'd4;
      nbusy = 0; done_cyc = 0; saw_hit = 0;
      for (int c = 1; c <= 20; c++) begin
         if (busy0) nbusy++;
         if (done0) done_cyc = c;
         if (c >= 2 && hit0) saw_hit++;
         if (!busy0) break;
         tick();
      end
      req = 1'b0;
      check("sel_flush_busy_cycles", 64'(nbusy), 64'd9);
      check("sel_flush_done_cycle", 64'(done_cyc), 64'd9);
      check("busy_lookups_miss", 64'(saw_hit), 64'd0);
      check("busy_counters_frozen", acc0, acc_before);
      lookup(64'h0020_0123, 16'd3);
      check("global_survives", hit0, 1);
      lookup(64'h5000_3000, 16'd3);
      check("asid3_flushed", hit0, 0);
      lookup(64'h5000_4000, 16'd4);
      check("asid4_survives", hit0, 1);

      // ---- reset in the middle of a sweep ----
      install(64'h6000_0000, 16'd2, 1'b0, 64'h6_0000_0000, Pg4K, 5'b11111);
      lookup(64'h6000_0000, 16'd2);
      check("pre_reset_hit", hit0, 1);
      flush_va_valid = 1'b1; flush_va = 64'h7777_0000; flush_req = 1'b1;
      tick();
      flush_req = 1'b0; flush_va_valid = 1'b0;
      check("sweep_started", busy0, 1);
      tick(); tick(); tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("midsweep_reset_busy", busy0, 0);
      check("midsweep_reset_done", done0, 0);
      check("midsweep_reset_acc", acc0, 0);
      check("midsweep_reset_hits", hits0, 0);
      lookup(64'h6000_0000, 16'd2);
      check("post_reset_miss", hit0, 0);
      check("post_reset_acc", acc0, 64'd1);
      check("post_reset_hits", hits0, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
